// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the run-time controlled two-stage clock divider.
package clk_div_pkg;

  localparam int unsigned DWidthDef  = 16;
  localparam int unsigned Div1RstDef = 25;
  localparam int unsigned Div2RstDef = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StLoad
  } clk_div_state_t;

endpackage

// File: rtl/clk_div_core.sv
// Two-stage toggle divider datapath: prescale counter, phase bit, second counter, output flop.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned D_WIDTH = DWidthDef
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               run_i,
  input  logic               clr_i,
  input  logic               suppress_rise_i,
  input  logic [D_WIDTH-1:0] div1_i,
  input  logic [D_WIDTH-1:0] div2_i,
  output logic               clk_out_o,
  output logic               rise_evt_o
);

  localparam logic [D_WIDTH-1:0] One = D_WIDTH'(1);

  logic [D_WIDTH-1:0] cnt1_q, cnt1_d;
  logic [D_WIDTH-1:0] cnt2_q, cnt2_d;
  logic               ph1_q, ph1_d;
  logic               clk_out_q, clk_out_d;
  logic               t1, adv2, tog;

  always_comb begin
    t1         = (cnt1_q == '0);
    adv2       = t1 && !ph1_q;
    tog        = adv2 && (cnt2_q == '0);
    rise_evt_o = run_i && tog && !clk_out_q;

    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    ph1_d     = ph1_q;
    clk_out_d = clk_out_q;

    if (clr_i) begin
      cnt1_d    = '0;
      cnt2_d    = '0;
      ph1_d     = 1'b0;
      clk_out_d = 1'b0;
    end else if (run_i) begin
      cnt1_d = (cnt1_q >= div1_i - One) ? '0 : cnt1_q + One;
      if (t1) ph1_d = !ph1_q;
      if (adv2) cnt2_d = (cnt2_q >= div2_i - One) ? '0 : cnt2_q + One;
      // A suppressed rise leaves the output low; falls are never suppressed.
      if (tog && !(suppress_rise_i && !clk_out_q)) clk_out_d = !clk_out_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      ph1_q     <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      ph1_q     <= ph1_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out_o = clk_out_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: ratio handshake, pending ratios, and glitch-free apply/stop at a rise boundary.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned D_WIDTH  = DWidthDef,
  parameter int unsigned DIV1_RST = Div1RstDef,
  parameter int unsigned DIV2_RST = Div2RstDef
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_valid,
  input  logic [D_WIDTH-1:0] cfg_div1,
  input  logic [D_WIDTH-1:0] cfg_div2,
  output logic               cfg_ready,
  output logic               cfg_done,
  output logic               cfg_err,
  output logic               clk_out,
  output logic               busy,
  output logic [D_WIDTH-1:0] cur_div1,
  output logic [D_WIDTH-1:0] cur_div2
);

  clk_div_state_t     state_q, state_d;
  logic [D_WIDTH-1:0] cur1_q, cur1_d, cur2_q, cur2_d;
  logic [D_WIDTH-1:0] pend1_q, pend1_d, pend2_q, pend2_d;
  logic               pend_valid_q, pend_valid_d;
  logic               cfg_done_q, cfg_err_q, busy_q;
  logic               xfer, cfg_bad, cfg_ok;
  logic               core_run, core_clr, core_suppress, rise_evt;

  always_comb begin
    cfg_ready = (state_q == StIdle) || (state_q == StRun);
    xfer      = cfg_valid && cfg_ready;
    cfg_bad   = xfer && ((cfg_div1 == '0) || (cfg_div2 == '0));
    cfg_ok    = xfer && !cfg_bad;
    core_run  = (state_q == StRun) || (state_q == StDrain);

    state_d       = state_q;
    cur1_d        = cur1_q;
    cur2_d        = cur2_q;
    pend1_d       = pend1_q;
    pend2_d       = pend2_q;
    pend_valid_d  = pend_valid_q;
    core_clr      = 1'b0;
    core_suppress = 1'b0;

    if (cfg_ok) begin
      pend_valid_d = 1'b1;
      pend1_d      = cfg_div1;
      pend2_d      = cfg_div2;
    end

    unique case (state_q)
      StIdle: begin
        core_clr = 1'b1;
        if (cfg_ok)  state_d = StLoad;
        else if (en) state_d = StRun;
      end
      StRun: begin
        if (cfg_ok || !en) state_d = StDrain;
      end
      StDrain: begin
        // Only a rise is a safe boundary: the output is low and a full period has ended.
        if (rise_evt) begin
          if (pend_valid_q) begin
            state_d       = StLoad;
            core_suppress = 1'b1;
            core_clr      = 1'b1;
          end else if (!en) begin
            state_d       = StIdle;
            core_suppress = 1'b1;
            core_clr      = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StLoad: begin
        core_clr     = 1'b1;
        cur1_d       = pend1_q;
        cur2_d       = pend2_q;
        pend_valid_d = 1'b0;
        state_d      = en ? StRun : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cur1_q       <= D_WIDTH'(DIV1_RST);
      cur2_q       <= D_WIDTH'(DIV2_RST);
      pend1_q      <= '0;
      pend2_q      <= '0;
      pend_valid_q <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur1_q       <= cur1_d;
      cur2_q       <= cur2_d;
      pend1_q      <= pend1_d;
      pend2_q      <= pend2_d;
      pend_valid_q <= pend_valid_d;
      cfg_done_q   <= (state_d == StLoad);
      cfg_err_q    <= cfg_bad;
      busy_q       <= (state_d != StIdle);
    end
  end

  clk_div_core #(
    .D_WIDTH(D_WIDTH)
  ) u_core (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .run_i          (core_run),
    .clr_i          (core_clr),
    .suppress_rise_i(core_suppress),
    .div1_i         (cur1_q),
    .div2_i         (cur2_q),
    .clk_out_o      (clk_out),
    .rise_evt_o     (rise_evt)
  );

  assign cfg_done = cfg_done_q;
  assign cfg_err  = cfg_err_q;
  assign busy     = busy_q;
  assign cur_div1 = cur1_q;
  assign cur_div2 = cur2_q;

endmodule
